// File: rtl/csadd_operand_feeder_if.sv
// Handshake and serial-output bundle between an operand source, the
// csadd_operand_feeder and the bit-serial carry-save adder.
interface csadd_operand_feeder_if #(parameter int W = 8);
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_valid;
  logic         in_ready;
  logic         x;
  logic         y;
  logic         out_vld;
  logic         out_first;
  logic         out_last;

  modport master (output in_a, in_b, in_valid,
                  input  in_ready, x, y, out_vld, out_first, out_last);
  modport slave  (input  in_a, in_b, in_valid,
                  output in_ready, x, y, out_vld, out_first, out_last);
endinterface

// File: rtl/csadd_operand_feeder.sv
// Parallel-to-serial operand feeder for the bit-serial carry-save adder: W+1 cycle
// frames (W data bits LSB-first plus one zero pad). CSADD_FEEDER_SKID_EN adds a
// one-entry pending buffer for back-to-back frames.
module csadd_operand_feeder #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  csadd_operand_feeder_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  pair_t         sh;
  logic          live;
  logic          hs;
  logic          pad;

  assign pad = (state == SHIFT) && (cnt == CW'(W));

`ifdef CSADD_FEEDER_SKID_EN
  pair_t pend;
  logic  pend_full;
  assign bus.in_ready = live & ((state == IDLE) | ((state == SHIFT) & ~pend_full));
`else
  assign bus.in_ready = live & (state == IDLE);
`endif

  assign hs = bus.in_valid & bus.in_ready;

  // Shift registers drain to zero after W shifts, so the pad cycle and IDLE
  // present x=y=0 straight from the flops.
  assign bus.x         = sh.a[0];
  assign bus.y         = sh.b[0];
  assign bus.out_vld   = (state == SHIFT);
  assign bus.out_first = (state == SHIFT) && (cnt == '0);
  assign bus.out_last  = pad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      live  <= 1'b0;
`ifdef CSADD_FEEDER_SKID_EN
      pend      <= '0;
      pend_full <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      if (state == IDLE) begin
        if (hs) begin
          state <= SHIFT;
          cnt   <= '0;
          sh    <= '{a: bus.in_a, b: bus.in_b};
        end
      end else if (!pad) begin
        cnt  <= cnt + 1'b1;
        sh.a <= sh.a >> 1;
        sh.b <= sh.b >> 1;
`ifdef CSADD_FEEDER_SKID_EN
        if (hs) begin
          pend      <= '{a: bus.in_a, b: bus.in_b};
          pend_full <= 1'b1;
        end
`endif
      end else begin
`ifdef CSADD_FEEDER_SKID_EN
        // Pad cycle: a buffered pair, or one handed over right now, starts
        // the next frame with no bubble.
        if (pend_full) begin
          sh        <= pend;
          cnt       <= '0;
          pend_full <= 1'b0;
        end else if (hs) begin
          sh  <= '{a: bus.in_a, b: bus.in_b};
          cnt <= '0;
        end else begin
          state <= IDLE;
        end
`else
        state <= IDLE;
`endif
      end
    end
  end
endmodule

// File: tb/tb_csadd_operand_feeder.sv
// Randomized/directed bench for csadd_operand_feeder against a frame-stream
// model, plus a bit-serial adder model to check the assembled sums.
module tb_csadd_operand_feeder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csadd_operand_feeder_if #(.W(W)) bus ();
  csadd_operand_feeder_if #(.W(2)) bus2 ();

  csadd_operand_feeder #(.W(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  csadd_operand_feeder #(.W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Downstream bit-serial adder sharing rst
  logic s_q, c_q, av_q, af_q, al_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 1'b0; c_q <= 1'b0; av_q <= 1'b0; af_q <= 1'b0; al_q <= 1'b0;
    end else begin
      s_q  <= bus.x ^ bus.y ^ c_q;
      c_q  <= (bus.x & bus.y) | (c_q & (bus.x ^ bus.y));
      av_q <= bus.out_vld;
      af_q <= bus.out_first;
      al_q <= bus.out_last;
    end
  end

  typedef struct packed { logic x; logic y; logic f; logic l; } beat_t;
  beat_t        bq[$];   // expected output beats, front = current cycle
  logic [W:0]   sq[$];   // expected adder results
  bit           live;
  int           vecs, fails;
  logic [W:0]   acc_s;
  int           kk;
  int           run, max_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rdy_exp();
`ifdef CSADD_FEEDER_SKID_EN
    return live && (bq.size() <= W + 1);
`else
    return live && (bq.size() == 0);
`endif
  endfunction

  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    beat_t e;
    bit    acc;
    e = (bq.size() != 0) ? bq[0] : '0;
    bus.in_valid = v; bus.in_a = a; bus.in_b = b;
    #1;
    chk("in_ready",  bus.in_ready,  rdy_exp());
    chk("out_vld",   bus.out_vld,   bq.size() != 0);
    chk("x",         bus.x,         e.x);
    chk("y",         bus.y,         e.y);
    chk("out_first", bus.out_first, e.f);
    chk("out_last",  bus.out_last,  e.l);
    if (bus.out_vld) run++; else run = 0;
    if (run > max_run) max_run = run;
    if (av_q) begin
      if (af_q) begin acc_s = '0; kk = 0; end
      if (kk <= W) acc_s[kk] = s_q;
      kk++;
      if (al_q) begin
        if (sq.size() == 0) chk("sum_unexpected", 1, 0);
        else chk("adder_sum", acc_s, sq.pop_front());
      end
    end
    acc = v && rdy_exp();
    @(posedge clk);
    if (bq.size() != 0) void'(bq.pop_front());
    if (acc) begin
      for (int k = 0; k <= W; k++) begin
        if (k < W) bq.push_back('{x: a[k], y: b[k], f: (k == 0), l: 1'b0});
        else       bq.push_back('{x: 1'b0, y: 1'b0, f: 1'b0, l: 1'b1});
      end
      sq.push_back({1'b0, a} + {1'b0, b});
    end
    if (!rst) live = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bus.in_a, bus.in_b);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int g;
    bit acc;
    g = 0; acc = 1'b0;
    while (!acc && g < 40) begin
      acc = rdy_exp();
      step(1'b1, a, b);
      g++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  initial begin
    logic [1:0] a2;
    logic [2:0] s2;
    logic       c2;
    vecs = 0; fails = 0; live = 1'b0; kk = 0; acc_s = '0; run = 0; max_run = 0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0;

    // Reset state
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single frame 0x5A + 0x3C = 0x096
    send(8'h5A, 8'h3C);
    idle(12);

    // Carry flush: 0xFF+0x01 then 0x01+0x01
    send(8'hFF, 8'h01);
    send(8'h01, 8'h01);
    idle(14);

    // Three pairs with in_valid held high
    max_run = 0;
    send(8'hA5, 8'h5A);
    send(8'h80, 8'h80);
    send(8'h7F, 8'h01);
    idle(14);
`ifdef CSADD_FEEDER_SKID_EN
    chk("burst_run", max_run, 3 * (W + 1));
`else
    chk("burst_run", max_run, W + 1);
`endif

    // Reset at cnt=4 while a second pair is offered (pending in the skid build)
    send(8'h11, 8'h22);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h33, 8'h44);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_vld",  bus.out_vld,   0);
    chk("rst_x",        bus.x,         0);
    chk("rst_y",        bus.y,         0);
    chk("rst_first",    bus.out_first, 0);
    chk("rst_last",     bus.out_last,  0);
    chk("rst_in_ready", bus.in_ready,  0);
    bq.delete(); sq.delete(); live = 1'b0;
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(25);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) step(1'b1, W'($urandom), W'($urandom));
      else                           step(1'b0, bus.in_a, bus.in_b);
    end
    idle(25);

    // W=2 boundary: 3 + 3 = 0b110 over a 3-cycle frame
    a2 = 2'd3;
    chk("w2_ready", bus2.in_ready, 1);
    bus2.in_a = a2; bus2.in_b = a2; bus2.in_valid = 1'b1;
    @(posedge clk);
    #1 bus2.in_valid = 1'b0;
    @(negedge clk);
    s2 = '0; c2 = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      chk("w2_vld",   bus2.out_vld,   1);
      chk("w2_first", bus2.out_first, k == 0);
      chk("w2_last",  bus2.out_last,  k == 2);
      chk("w2_x",     bus2.x,         (k < 2) ? a2[k] : 1'b0);
      chk("w2_y",     bus2.y,         (k < 2) ? a2[k] : 1'b0);
      s2[k] = bus2.x ^ bus2.y ^ c2;
      c2    = (bus2.x & bus2.y) | (c2 & (bus2.x ^ bus2.y));
      @(negedge clk);
    end
    chk("w2_sum",  s2, 3'b110);
    chk("w2_idle", bus2.out_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
